// File: rtl/comp_seq_pkg.sv
// Shared types and constants for the nibble-serial comparator sequencer.
package comp_seq_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Result codes as {K, L}, matching the COMP_4 output encoding.
  localparam logic [1:0] RES_GT = 2'b10;
  localparam logic [1:0] RES_LT = 2'b01;
  localparam logic [1:0] RES_EQ = 2'b11;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StCmp  = ST_CMP,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/comp_seq_ctrl.sv
// Time-shares one external 4-bit comparator to compare two wide operands, MS nibble first,
// stopping on the first unequal nibble.
module comp_seq_ctrl
  import comp_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned CNT_W   = $clog2(NIBBLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [NIB_W*NIBBLES-1:0] A_i,
  input  logic [NIB_W*NIBBLES-1:0] B_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     K_o,
  output logic                     L_o,
  output logic [CNT_W-1:0]         cycles_o,
  output logic [NIB_W-1:0]         cmp_x_o,
  output logic [NIB_W-1:0]         cmp_y_o,
  input  logic                     cmp_k_i,
  input  logic                     cmp_l_i
);

  localparam int unsigned W     = NIB_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             k_q, k_d;
  logic             l_q, l_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      k_q      <= 1'b0;
      l_q      <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      l_q      <= l_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    l_d      = l_q;
    cycles_d = cycles_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = A_i;
          b_d     = B_i;
          idx_d   = IDX_W'(NIBBLES - 1);
          cnt_d   = '0;
          state_d = StCmp;
        end
      end
      StCmp: begin
        cnt_d = cnt_q + CNT_W'(1);
        case ({cmp_k_i, cmp_l_i})
          RES_EQ: begin
            if (idx_q != '0) begin
              idx_d = idx_q - IDX_W'(1);
            end else begin
              {k_d, l_d} = RES_EQ;
              cycles_d   = cnt_d;
              state_d    = StDone;
            end
          end
          RES_GT, RES_LT: begin
            {k_d, l_d} = {cmp_k_i, cmp_l_i};
            cycles_d   = cnt_d;
            state_d    = StDone;
          end
          default: begin
            // Illegal comparator output is passed through rather than masked.
            {k_d, l_d} = 2'b00;
            cycles_d   = cnt_d;
            state_d    = StDone;
          end
        endcase
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == StCmp);
    done_o   = (state_q == StDone);
    K_o      = k_q;
    L_o      = l_q;
    cycles_o = cycles_q;
    cmp_x_o  = '0;
    cmp_y_o  = '0;
    if (state_q == StCmp) begin
      cmp_x_o = a_q[int'(idx_q) * NIB_W +: NIB_W];
      cmp_y_o = b_q[int'(idx_q) * NIB_W +: NIB_W];
    end
  end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Self-checking bench: wide-compare model checked every cycle, plus directed literal results.
module tb_comp_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-nibble instance
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        illegal = 1'b0;
  logic        busy, done, k_o, l_o, ck, cl;
  logic [2:0]  cyc;
  logic [3:0]  cx, cy;

  assign ck = illegal ? 1'b0 : (cx >= cy);
  assign cl = illegal ? 1'b0 : (cx <= cy);

  comp_seq_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .A_i(a), .B_i(b),
    .busy_o(busy), .done_o(done), .K_o(k_o), .L_o(l_o), .cycles_o(cyc),
    .cmp_x_o(cx), .cmp_y_o(cy), .cmp_k_i(ck), .cmp_l_i(cl)
  );

  // 1-nibble instance
  logic       start1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0;
  logic       busy1, done1, k1, l1, ck1, cl1;
  logic [0:0] cyc1;
  logic [3:0] cx1, cy1;

  assign ck1 = (cx1 >= cy1);
  assign cl1 = (cx1 <= cy1);

  comp_seq_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .A_i(a1), .B_i(b1),
    .busy_o(busy1), .done_o(done1), .K_o(k1), .L_o(l1), .cycles_o(cyc1),
    .cmp_x_o(cx1), .cmp_y_o(cy1), .cmp_k_i(ck1), .cmp_l_i(cl1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Whole-operand model: first differing nibble from the top decides result and length.
  function automatic void predict(input logic [15:0] pa, input logic [15:0] pb, input logic ill,
                                  output logic pk, output logic pl, output int pn);
    logic [3:0] na, nb;
    pk = 1'b1;
    pl = 1'b1;
    pn = 4;
    if (ill) begin
      pk = 1'b0;
      pl = 1'b0;
      pn = 1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      na = pa[(3 - i) * 4 +: 4];
      nb = pb[(3 - i) * 4 +: 4];
      if (na != nb) begin
        pk = (na > nb);
        pl = (na < nb);
        pn = i + 1;
        return;
      end
    end
  endfunction

  // m_t: 0 idle, 1..m_n compare cycles, m_n+1 done cycle
  int          m_t = 0, m_n = 0, m_cyc = 0;
  logic        m_k = 1'b0, m_l = 1'b0, m_ko = 1'b0, m_lo = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;

  always @(posedge clk or posedge rst) begin
    logic pk, pl;
    int   pn;
    if (rst) begin
      m_t   <= 0;
      m_ko  <= 1'b0;
      m_lo  <= 1'b0;
      m_cyc <= 0;
    end else if (m_t == 0) begin
      if (start) begin
        predict(a, b, illegal, pk, pl, pn);
        m_a <= a;
        m_b <= b;
        m_k <= pk;
        m_l <= pl;
        m_n <= pn;
        m_t <= 1;
      end
    end else if (m_t <= m_n) begin
      m_t <= m_t + 1;
      if (m_t == m_n) begin
        m_ko  <= m_k;
        m_lo  <= m_l;
        m_cyc <= m_n;
      end
    end else begin
      m_t <= 0;
    end
  end

  always @(negedge clk) begin
    logic       eb;
    logic [3:0] ex, ey;
    eb = (m_t >= 1) && (m_t <= m_n);
    ex = eb ? m_a[(4 - m_t) * 4 +: 4] : 4'h0;
    ey = eb ? m_b[(4 - m_t) * 4 +: 4] : 4'h0;
    chk("busy", int'(busy), int'(eb));
    chk("done", int'(done), int'((m_t != 0) && (m_t == m_n + 1)));
    chk("K", int'(k_o), int'(m_ko));
    chk("L", int'(l_o), int'(m_lo));
    chk("cycles", int'(cyc), m_cyc);
    chk("cmp_x", int'(cx), int'(ex));
    chk("cmp_y", int'(cy), int'(ey));
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [15:0] pa, input logic [15:0] pb, output logic [3:0] fx,
                       output logic [3:0] fy, output logic rk, output logic rl, output int rc);
    @(negedge clk);
    a = pa;
    b = pb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fx = cx;
    fy = cy;
    if (!done) wait_done();
    rk = k_o;
    rl = l_o;
    rc = int'(cyc);
  endtask

  logic [3:0] fx, fy;
  logic       rk, rl;
  int         rc;
  logic [3:0] ta [3] = '{4'h3, 4'h9, 4'h5};
  logic [3:0] tb [3] = '{4'h9, 4'h3, 4'h5};
  logic       tk [3] = '{1'b0, 1'b1, 1'b1};
  logic       tl [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_K", int'(k_o), 0);
    chk("rst_cycles", int'(cyc), 0);

    do_op(16'h0000, 16'h0000, fx, fy, rk, rl, rc);
    chk("eq0_K", int'(rk), 1); chk("eq0_L", int'(rl), 1); chk("eq0_cyc", rc, 4);

    do_op(16'h8000, 16'h7FFF, fx, fy, rk, rl, rc);
    chk("msb_x", int'(fx), 8); chk("msb_y", int'(fy), 7);
    chk("msb_K", int'(rk), 1); chk("msb_L", int'(rl), 0); chk("msb_cyc", rc, 1);

    do_op(16'h12C0, 16'h12E0, fx, fy, rk, rl, rc);
    chk("mid_K", int'(rk), 0); chk("mid_L", int'(rl), 1); chk("mid_cyc", rc, 3);

    do_op(16'hFFFF, 16'hFFFE, fx, fy, rk, rl, rc);
    chk("lsb_K", int'(rk), 1); chk("lsb_L", int'(rl), 0); chk("lsb_cyc", rc, 4);

    // Second start while busy must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h0000; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("repulse_K", int'(k_o), 1); chk("repulse_L", int'(l_o), 1);
    chk("repulse_cyc", int'(cyc), 4);

    // Asynchronous reset in the middle of a compare.
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0); chk("arst_done", int'(done), 0);
    chk("arst_K", int'(k_o), 0); chk("arst_L", int'(l_o), 0);
    chk("arst_cyc", int'(cyc), 0); chk("arst_x", int'(cx), 0); chk("arst_y", int'(cy), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_done", int'(done), 0);
    end

    do_op(16'h00F0, 16'h0F00, fx, fy, rk, rl, rc);
    chk("post_K", int'(rk), 0); chk("post_L", int'(rl), 1); chk("post_cyc", rc, 2);

    illegal = 1'b1;
    do_op(16'h5555, 16'h5555, fx, fy, rk, rl, rc);
    illegal = 1'b0;
    chk("ill_K", int'(rk), 0); chk("ill_L", int'(rl), 0); chk("ill_cyc", rc, 1);

    // Single-nibble build, starts every 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a1 = ta[i]; b1 = tb[i]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("n1_busy", int'(busy1), 1);
      @(negedge clk);
      chk("n1_done", int'(done1), 1);
      chk("n1_K", int'(k1), int'(tk[i]));
      chk("n1_L", int'(l1), int'(tl[i]));
      chk("n1_cyc", int'(cyc1), 1);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
